// File: rtl/output_converter_pkg.sv
// Shared state encoding and width derivation for the result-stream output converter.
package output_converter_pkg;

    localparam int unsigned PTS_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_LOAD  = 2'd2,
        ST_SEND  = 2'd3
    } state_e;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int unsigned clogb2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) result = i + 1;
        end
        return result;
    endfunction

    function automatic int unsigned calc_beats(input int unsigned word_w, input int unsigned stream_w);
        return (word_w <= stream_w) ? 1 : word_w / stream_w;
    endfunction

    function automatic int unsigned calc_beat_w(input int unsigned word_w, input int unsigned stream_w);
        int unsigned w;
        w = clogb2(calc_beats(word_w, stream_w));
        return (w == 0) ? 1 : w;
    endfunction

    function automatic bit widths_legal(input int unsigned word_w, input int unsigned stream_w);
        return (stream_w != 0) && ((word_w <= stream_w) || ((word_w % stream_w) == 0));
    endfunction

endpackage

// File: rtl/output_converter_if.sv
// AXI-Stream transmit channel carrying serialised result words.
interface output_converter_if #(
    parameter int unsigned STREAM_WIDTH = 256
);
    logic [STREAM_WIDTH-1:0] m_axis_tdata;
    logic                    m_axis_tvalid;
    logic                    m_axis_tlast;
    logic                    m_axis_tready;

    modport master (
        output m_axis_tdata,
        output m_axis_tvalid,
        output m_axis_tlast,
        input  m_axis_tready
    );

    modport slave (
        input  m_axis_tdata,
        input  m_axis_tvalid,
        input  m_axis_tlast,
        output m_axis_tready
    );
endinterface

// File: rtl/output_converter_serializer.sv
// Holds one result word and presents it LSB slice first as stream beats.
module output_serializer
    import output_converter_pkg::*;
#(
    parameter int unsigned STREAM_WIDTH = 256,
    parameter int unsigned WORD_WIDTH   = 128
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i_load,
    input  logic [WORD_WIDTH-1:0]   i_word,
    input  logic                    i_send,
    input  logic                    i_tready,
    input  logic                    i_last_pt,
    output logic [STREAM_WIDTH-1:0] o_tdata_c,
    output logic                    o_tlast_c,
    output logic                    o_final_beat_c
);
    localparam int unsigned BEATS  = calc_beats(WORD_WIDTH, STREAM_WIDTH);
    localparam int unsigned BEAT_W = calc_beat_w(WORD_WIDTH, STREAM_WIDTH);
    localparam int unsigned REG_W  = BEATS * STREAM_WIDTH;

    logic [REG_W-1:0]  word_q, word_d;
    logic [BEAT_W-1:0] beat_q, beat_d;

    assign o_final_beat_c = (beat_q == BEAT_W'(BEATS - 1));
    assign o_tlast_c      = i_send & o_final_beat_c & i_last_pt;

    // Load zero-extends narrow words; beat only advances on a non-final handshake.
    always_comb begin
        word_d = word_q;
        beat_d = beat_q;
        if (i_load) begin
            word_d = REG_W'(i_word);
            beat_d = '0;
        end else if (i_send && i_tready && !o_final_beat_c) begin
            beat_d = beat_q + BEAT_W'(1);
        end
    end

    always_comb begin
        o_tdata_c = '0;
        for (int unsigned b = 0; b < BEATS; b++) begin
            if (beat_q == BEAT_W'(b)) o_tdata_c = word_q[b*STREAM_WIDTH +: STREAM_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            word_q <= '0;
            beat_q <= '0;
        end else begin
            word_q <= word_d;
            beat_q <= beat_d;
        end
    end

endmodule

// File: rtl/output_converter.sv
// Drains result words from the FIFO and streams them out, one job of N points per start pulse.
module output_converter
    import output_converter_pkg::*;
#(
    parameter int unsigned STREAM_WIDTH = 256,
    parameter int unsigned PRECISION    = 32,
    parameter int unsigned DIMENSION    = 4,
    parameter int unsigned WORD_WIDTH   = DIMENSION * PRECISION
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_start,
    input  logic [PTS_W-1:0]      i_num_pts,
    input  logic                  i_fifo_empty,
    input  logic [WORD_WIDTH-1:0] i_fifo_data,
    output logic                  o_fifo_read,
    output_converter_if.master    m_axis,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [PTS_W-1:0]      SENT_PTS
);
    if (!widths_legal(WORD_WIDTH, STREAM_WIDTH)) begin : g_illegal_width
        $error("output_converter: WORD_WIDTH must be <= STREAM_WIDTH or a multiple of it");
    end

    state_e           state_q, state_d;
    logic [PTS_W-1:0] count_q, count_d;
    logic [PTS_W-1:0] sent_pts_q, sent_pts_d;
    logic             done_q, done_d;
    logic             fifo_read_c;
    logic             final_beat_c;
    logic             last_pt_c;
    logic             send_c;

    assign send_c    = (state_q == ST_SEND);
    assign last_pt_c = (sent_pts_q == count_q - 64'd1);

    output_serializer #(
        .STREAM_WIDTH (STREAM_WIDTH),
        .WORD_WIDTH   (WORD_WIDTH)
    ) u_serializer (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_load         (state_q == ST_LOAD),
        .i_word         (i_fifo_data),
        .i_send         (send_c),
        .i_tready       (m_axis.m_axis_tready),
        .i_last_pt      (last_pt_c),
        .o_tdata_c      (m_axis.m_axis_tdata),
        .o_tlast_c      (m_axis.m_axis_tlast),
        .o_final_beat_c (final_beat_c)
    );

    // Job sequencing: one FIFO pop per point, then that point's beats.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        sent_pts_d  = sent_pts_q;
        done_d      = 1'b0;
        fifo_read_c = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    sent_pts_d = '0;
                    if (i_num_pts != '0) begin
                        count_d = i_num_pts;
                        state_d = ST_FETCH;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_FETCH: begin
                if (!i_fifo_empty) begin
                    fifo_read_c = 1'b1;
                    state_d     = ST_LOAD;
                end
            end
            ST_LOAD: state_d = ST_SEND;
            ST_SEND: begin
                if (m_axis.m_axis_tready && final_beat_c) begin
                    sent_pts_d = sent_pts_q + 64'd1;
                    if (sent_pts_q + 64'd1 == count_q) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            sent_pts_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            sent_pts_q <= sent_pts_d;
            done_q     <= done_d;
        end
    end

    assign o_fifo_read          = fifo_read_c;
    assign m_axis.m_axis_tvalid = send_c;
    assign o_busy               = (state_q != ST_IDLE);
    assign o_done               = done_q;
    assign SENT_PTS             = sent_pts_q;

endmodule
